// File: rtl/pair_triple_stimulus_driver.sv
// Self-test driver for a three-input majority detector: walks all 8 input
// vectors, samples the detector response and tallies ones, mismatches and the first mismatch.
module pair_triple_stimulus_driver #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in0,
    output logic       in1,
    output logic       in2,
    input  logic       det_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_count,
    output logic [3:0] err_count,
    output logic [2:0] first_err_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic       expected;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign expected = majority(in0, in1, in2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 3'd0;
            settle_cnt    <= 4'd0;
            {in2, in1, in0} <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_count    <= 4'd0;
            err_count     <= 4'd0;
            first_err_idx <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        idx             <= 3'd0;
                        settle_cnt      <= 4'd0;
                        {in2, in1, in0} <= 3'b000;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass_count      <= 4'd0;
                        err_count       <= 4'd0;
                        first_err_idx   <= 3'd0;
                    end
                end
                RUN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        pass_count <= pass_count + {3'b000, det_out};
                        if (det_out != expected) begin
                            err_count <= err_count + 4'd1;
                            if (err_count == 4'd0)
                                first_err_idx <= idx;
                        end
                        if (idx == 3'd7) begin
                            state           <= DONE;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            {in2, in1, in0} <= 3'b000;
                        end else begin
                            // Drive the next vector on the same edge so it gets a full SETTLE window.
                            idx             <= idx + 3'd1;
                            settle_cnt      <= 4'd0;
                            {in2, in1, in0} <= idx + 3'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_triple_stimulus_driver.sv
// Bench for pair_triple_stimulus_driver: two instances (SETTLE=1 and SETTLE=3) driving
// a truth-table detector, checked against a counting-based reference model.
module tb_pair_triple_stimulus_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sel;
    logic [7:0] tt1, tt3;

    logic       in0_1, in1_1, in2_1, det_1, busy_1, done_1;
    logic [3:0] pass_1, err_1;
    logic [2:0] fe_1;
    logic       in0_3, in1_3, in2_3, det_3, busy_3, done_3;
    logic [3:0] pass_3, err_3;
    logic [2:0] fe_3;
    logic       start_1, start_3;

    assign start_1 = start & ~sel;
    assign start_3 = start & sel;
    assign det_1   = tt1[{in2_1, in1_1, in0_1}];
    assign det_3   = tt3[{in2_3, in1_3, in0_3}];

    pair_triple_stimulus_driver #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_1),
        .in0(in0_1), .in1(in1_1), .in2(in2_1), .det_out(det_1),
        .busy(busy_1), .done(done_1), .pass_count(pass_1),
        .err_count(err_1), .first_err_idx(fe_1)
    );

    pair_triple_stimulus_driver #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_3),
        .in0(in0_3), .in1(in1_3), .in2(in2_3), .det_out(det_3),
        .busy(busy_3), .done(done_3), .pass_count(pass_3),
        .err_count(err_3), .first_err_idx(fe_3)
    );

    int checks = 0;
    int errors = 0;

    function automatic int o_ins();  return sel ? int'({in2_3, in1_3, in0_3}) : int'({in2_1, in1_1, in0_1}); endfunction
    function automatic int o_busy(); return sel ? int'(busy_3) : int'(busy_1); endfunction
    function automatic int o_done(); return sel ? int'(done_3) : int'(done_1); endfunction
    function automatic int o_pass(); return sel ? int'(pass_3) : int'(pass_1); endfunction
    function automatic int o_err();  return sel ? int'(err_3)  : int'(err_1);  endfunction
    function automatic int o_fe();   return sel ? int'(fe_3)   : int'(fe_1);   endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a vector should assert when at least two of its three bits are set.
    task automatic model(input logic [7:0] tt, output int p, output int e, output int fe);
        p = 0; e = 0; fe = -1;
        for (int v = 0; v < 8; v++) begin
            int ones;
            bit maj;
            ones = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
            maj  = (ones >= 2);
            if (tt[v]) p++;
            if (tt[v] != maj) begin
                e++;
                if (fe < 0) fe = v;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ins"},  o_ins(),  0);
        check({tag, "_busy"}, o_busy(), 0);
        check({tag, "_done"}, o_done(), 0);
        check({tag, "_pass"}, o_pass(), 0);
        check({tag, "_err"},  o_err(),  0);
        check({tag, "_fe"},   o_fe(),   0);
    endtask

    task automatic sweep(input string tag, input logic [7:0] tt, input bit hold);
        int s, ep, ee, ef;
        s = sel ? 3 : 1;
        model(tt, ep, ee, ef);
        if (sel) tt3 = tt; else tt1 = tt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check({tag, "_start_pass"}, o_pass(), 0);
        check({tag, "_start_err"},  o_err(),  0);
        check({tag, "_start_fe"},   o_fe(),   0);
        for (int c = 0; c < 8 * s; c++) begin
            check({tag, "_vec"},  o_ins(),  c / s);
            check({tag, "_busy"}, o_busy(), 1);
            check({tag, "_done"}, o_done(), 0);
            @(posedge clk); #1;
        end
        check({tag, "_end_busy"}, o_busy(), 0);
        check({tag, "_end_done"}, o_done(), 1);
        check({tag, "_end_ins"},  o_ins(),  0);
        check({tag, "_pass"},     o_pass(), ep);
        check({tag, "_err"},      o_err(),  ee);
        if (ee != 0) check({tag, "_fe"}, o_fe(), ef);
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b1; start = 1'b0; sel = 1'b0; tt1 = 8'h00; tt3 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; check_zero("reset1");
        sel = 1'b1; check_zero("reset3");
        @(negedge clk); rst = 1'b0;

        sel = 1'b0;
        sweep("golden1", 8'hE8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", o_done(), 1);
        check("hold_pass", o_pass(), 4);
        sweep("stuck0", 8'h00, 1'b0);
        check("stuck0_fe_lit", o_fe(), 3);
        sweep("or_det", 8'hFE, 1'b0);
        check("or_fe_lit", o_fe(), 1);
        check("or_err_lit", o_err(), 3);
        check("or_pass_lit", o_pass(), 7);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            sweep("rand1", r, 1'b0);
        end

        sel = 1'b1;
        sweep("golden3", 8'hE8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            sweep("rand3", r, 1'b0);
        end

        // Abort mid-sweep with reset, outputs must clear before the next edge.
        tt3 = 8'($urandom);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk); rst = 1'b0;
        r = 8'($urandom);
        sweep("after_rst", r, 1'b0);

        sel = 1'b0;
        sweep("hold1_a", 8'h17, 1'b1);
        sweep("hold1_b", 8'hE8, 1'b0);
        sel = 1'b1;
        r = 8'($urandom);
        sweep("hold3_a", r, 1'b1);
        sweep("hold3_b", 8'hE8, 1'b0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
